// File: rtl/pe_token_collector_if.sv
// Handshake bundle between the token collector, its upstream issuer, the PE output and the downstream consumer.
interface pe_token_collector_if #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 15,
    parameter int DEPTH   = 8
);
    logic                         issue_valid;
    logic                         issue_ready;
    logic [WIDTH-1:0]             pe_data;
    logic [WIDTH-1:0]             out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;
    logic [$clog2(LATENCY+1)-1:0] inflight;

    modport master (
        output issue_valid, pe_data, out_ready,
        input  issue_ready, out_data, out_valid, occupancy, inflight
    );

    modport slave (
        input  issue_valid, pe_data, out_ready,
        output issue_ready, out_data, out_valid, occupancy, inflight
    );
endinterface

// File: rtl/pe_token_collector.sv
// Captures fixed-latency PE results into a credit-protected show-ahead FIFO.
// Defining PE_COLLECT_STATS_EN adds the stall_cnt and hwm statistics outputs.
module pe_token_collector #(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 15,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    pe_token_collector_if.slave        bus
`ifdef PE_COLLECT_STATS_EN
    ,
    output logic [15:0]                stall_cnt,
    output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(LATENCY + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = $clog2(DEPTH + LATENCY + 1);

    logic [LATENCY-1:0] r_vpipe;
    logic [LATENCY-1:0] w_vpipe_next;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [INF_W-1:0]   r_inflight;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_accept;
    logic               w_arrive;
    logic               w_pop;
    logic [SUM_W-1:0]   w_credit_used;

    // Credit counts both stored and in-flight tokens, so a write can never hit a full FIFO.
    assign w_credit_used   = SUM_W'(r_count) + SUM_W'(r_inflight);
    assign bus.issue_ready = w_credit_used < SUM_W'(DEPTH);
    assign w_accept        = bus.issue_valid && bus.issue_ready;
    assign w_arrive        = r_vpipe[LATENCY-1];
    assign bus.out_valid   = (r_count != '0);
    assign w_pop           = bus.out_valid && bus.out_ready;
    assign bus.out_data    = r_mem[r_rd_ptr];
    assign bus.occupancy   = r_count;
    assign bus.inflight    = r_inflight;

    generate
        if (LATENCY == 1) begin : g_vpipe_one
            assign w_vpipe_next = w_accept;
        end else begin : g_vpipe_shift
            assign w_vpipe_next = {r_vpipe[LATENCY-2:0], w_accept};
        end
    endgenerate

    // NOTE: default assignment first so every path drives w_count_next and no latch is inferred.
    always_comb begin
        w_count_next = r_count;
        if (w_arrive && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_arrive && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vpipe    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
        end else begin
            r_vpipe <= w_vpipe_next;
            r_count <= w_count_next;
            if (w_arrive) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_accept && !w_arrive) begin
                r_inflight <= r_inflight + INF_W'(1);
            end else if (!w_accept && w_arrive) begin
                r_inflight <= r_inflight - INF_W'(1);
            end
        end
    end

    // NOTE: storage is not reset; r_count gates out_valid, so stale entries are never presented.
    always_ff @(posedge clk) begin
        if (w_arrive && !rst) begin
            r_mem[r_wr_ptr] <= bus.pe_data;
        end
    end

`ifdef PE_COLLECT_STATS_EN
    logic [15:0]      r_stall_cnt;
    logic [CNT_W-1:0] r_hwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_hwm       <= '0;
        end else begin
            if (bus.issue_valid && !bus.issue_ready && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_count_next > r_hwm) begin
                r_hwm <= w_count_next;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign hwm       = r_hwm;
`endif
endmodule
